// File: rtl/upd1771c_cmd_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : upd1771c_cmd_tx_if                                            |
// | Purpose  : Host write channel into the uPD1771C command transmitter.     |
// |            Valid/ready byte handshake from the CPU write decode.         |
// | Signals  : wr_valid  host offers wr_data                                 |
// |            wr_data   command byte (8 bits)                               |
// |            wr_ready  transmitter FIFO can accept a byte                  |
// | Modports : master (host side), slave (transmitter side)                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface upd1771c_cmd_tx_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface
`default_nettype wire

// File: rtl/upd1771c_cmd_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : upd1771c_cmd_tx                                               |
// | Purpose  : Queues command bytes from the host and presents each one on   |
// |            the uPD1771C PA input, launched on a PHI2 phase pulse, held   |
// |            for HOLD_CLKS enabled clocks and followed by GAP_CLKS quiet.  |
// | Ports    : clk     system clock                                          |
// |            rst_n   asynchronous active-low reset                         |
// |            cken    clock enable shared with the sound MCU                |
// |            phi2p   PHI2 phase pulse (1 clk wide, cken-qualified)         |
// |            wr_bus  host write channel (valid/data/ready), slave side     |
// |            pa_o    byte driven to the MCU PA input                       |
// |            pa_wr   high while pa_o is in its hold window                 |
// |            busy    sequencer not idle                                    |
// |            level   bytes queued and not yet driven                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module upd1771c_cmd_tx #(
  parameter int DEPTH     = 4,   // power of 2, >= 2
  parameter int HOLD_CLKS = 8,   // >= 1
  parameter int GAP_CLKS  = 72   // >= 1
) (
  input  wire                         clk,
  input  wire                         rst_n,
  input  wire                         cken,
  input  wire                         phi2p,
  upd1771c_cmd_tx_if.slave            wr_bus,
  output logic [7:0]                  pa_o,
  output logic                        pa_wr,
  output logic                        busy,
  output logic [$clog2(DEPTH+1)-1:0]  level
);

  localparam int c_AW   = $clog2(DEPTH);
  localparam int c_LW   = $clog2(DEPTH + 1);
  localparam int c_CMAX = (HOLD_CLKS > GAP_CLKS) ? HOLD_CLKS : GAP_CLKS;
  localparam int c_CW   = $clog2(c_CMAX + 1);

  localparam logic [c_CW-1:0] c_HOLD_LOAD = c_CW'(HOLD_CLKS - 1);
  localparam logic [c_CW-1:0] c_GAP_LOAD  = c_CW'(GAP_CLKS - 1);
  localparam logic [c_LW-1:0] c_FULL      = c_LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_HOLD  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_LW-1:0] r_level;

  // Sequencer
  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] w_cnt_nxt;
  logic            r_pa_wr;
  logic            w_pa_wr_nxt;
  logic [7:0]      r_pa_o;

  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_has_data;

  assign w_ready    = (r_level != c_FULL);
  assign w_push     = wr_bus.wr_valid & w_ready;
  assign w_has_data = (r_level != '0);

  // Host side runs on every clk edge; cken only gates the sequencer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_bus.wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LW'(1);
        2'b01:   r_level <= r_level - c_LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pa_wr <= 1'b0;
      r_pa_o  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pa_wr <= w_pa_wr_nxt;
      // pa_o only ever changes at a pop; it keeps the last byte afterwards.
      if (w_pop) begin
        r_pa_o <= r_mem[r_rptr];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pa_wr_nxt = r_pa_wr;
    w_pop       = 1'b0;
    case (r_state)
      // Leaving idle does not wait for cken so the first byte can align
      // to the very next enabled phase pulse.
      S_IDLE: begin
        if (w_has_data) begin
          w_state_nxt = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (cken && phi2p && w_has_data) begin
          w_pop       = 1'b1;
          w_pa_wr_nxt = 1'b1;
          w_cnt_nxt   = c_HOLD_LOAD;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cken) begin
          if (r_cnt == '0) begin
            w_pa_wr_nxt = 1'b0;
            w_cnt_nxt   = c_GAP_LOAD;
            w_state_nxt = S_GAP;
          end else begin
            w_cnt_nxt = r_cnt - c_CW'(1);
          end
        end
      end
      S_GAP: begin
        if (cken) begin
          if (r_cnt == '0) begin
            w_state_nxt = w_has_data ? S_ALIGN : S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - c_CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign wr_bus.wr_ready = w_ready;
  assign pa_o            = r_pa_o;
  assign pa_wr           = r_pa_wr;
  assign busy            = (r_state != S_IDLE);
  assign level           = r_level;

endmodule
`default_nettype wire

// File: tb/tb_upd1771c_cmd_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_upd1771c_cmd_tx                                            |
// | Purpose  : Self-checking bench for upd1771c_cmd_tx: a table of per-clock |
// |            vectors followed by hand-written multi-cycle sequences.       |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_upd1771c_cmd_tx;

  logic       clk;
  logic       rst_n;
  logic       cken;
  logic       phi2p;
  logic [7:0] pa_o;
  logic       pa_wr;
  logic       busy;
  logic [2:0] level;

  // Phase pulse source: either a free-running 1-in-8 pulse or a manual level.
  logic phi_mode;
  logic phi_man;
  int   cyc;
  int   edges;
  int   n_vec;
  int   n_err;

  upd1771c_cmd_tx_if bus ();

  upd1771c_cmd_tx dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cken   (cken),
    .phi2p  (phi2p),
    .wr_bus (bus),
    .pa_o   (pa_o),
    .pa_wr  (pa_wr),
    .busy   (busy),
    .level  (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc moves on the falling edge so phi2p is stable at every rising edge.
  initial cyc = 0;
  always @(negedge clk) cyc = cyc + 1;
  assign phi2p = phi_mode ? (cyc[2:0] == 3'd0) : phi_man;

  typedef struct {
    logic       cken;
    logic       phi;
    logic       valid;
    logic [7:0] data;
    logic [7:0] e_pa_o;
    logic       e_pa_wr;
    logic       e_busy;
    logic [2:0] e_level;
    logic       e_ready;
  } vec_t;

  vec_t tbl [8];

  task automatic step();
    @(posedge clk);
    #1;
    edges = edges + 1;
  endtask

  task automatic check(input string name, input logic [7:0] e_pa_o, input logic e_pa_wr,
                       input logic e_busy, input logic [2:0] e_level, input logic e_ready);
    n_vec = n_vec + 1;
    if ({pa_o, pa_wr, busy, level, bus.wr_ready} !== {e_pa_o, e_pa_wr, e_busy, e_level, e_ready}) begin
      n_err = n_err + 1;
      $display("FAIL %s: got pa_o=%h pa_wr=%b busy=%b level=%0d ready=%b, want pa_o=%h pa_wr=%b busy=%b level=%0d ready=%b",
               name, pa_o, pa_wr, busy, level, bus.wr_ready, e_pa_o, e_pa_wr, e_busy, e_level, e_ready);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Step until pa_wr rises, then check the popped byte, level and that the
  // launch edge carried a phase pulse.
  task automatic wait_pop(input string name, input logic [7:0] e_data, input logic [2:0] e_lvl,
                          output int t_pop);
    logic prev;
    bit   seen;
    prev  = pa_wr;
    seen  = 1'b0;
    t_pop = edges;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      if (pa_wr && !prev) seen = 1'b1;
      else prev = pa_wr;
    end
    n_vec = n_vec + 1;
    if (!seen) begin
      n_err = n_err + 1;
      $display("FAIL %s: got no pop within 300 clocks, want pop of %h", name, e_data);
    end else begin
      t_pop = edges;
      if ({pa_o, level, phi2p} !== {e_data, e_lvl, 1'b1}) begin
        n_err = n_err + 1;
        $display("FAIL %s: got pa_o=%h level=%0d phi2p=%b, want pa_o=%h level=%0d phi2p=1",
                 name, pa_o, level, phi2p, e_data, e_lvl);
      end
    end
  endtask

  // Number of samples pa_wr stays high, counting the current (pop) sample.
  task automatic strobe_len(output int n);
    n = 1;
    for (int i = 0; i < 100 && pa_wr; i++) begin
      step();
      if (pa_wr) n = n + 1;
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && (busy || level != 3'd0); i++) step();
    n_vec = n_vec + 1;
    if (busy || level != 3'd0) begin
      n_err = n_err + 1;
      $display("FAIL %s: got busy=%b level=%0d after 400 clocks, want idle and empty", name, busy, level);
    end
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    int t;
    int t_prev;
    int n;
    logic [7:0] seq3 [3];

    n_vec = 0;
    n_err = 0;
    edges = 0;
    rst_n = 1'b0;
    cken  = 1'b1;
    phi_mode = 1'b0;
    phi_man  = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;

    //             cken phi val data   pa_o  wr busy lvl rdy
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h09, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd1, 1'b1}; // pulse in IDLE ignored
    tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd1, 1'b1}; // no pop without cken
    tbl[5] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h09, 1'b1, 1'b1, 3'd0, 1'b1}; // pop
    tbl[6] = '{1'b1, 1'b0, 1'b1, 8'h0A, 8'h09, 1'b1, 1'b1, 3'd1, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h0B, 8'h09, 1'b1, 1'b1, 3'd2, 1'b1}; // push with cken low

    step();
    step();
    check("reset_state", 8'h00, 1'b0, 1'b0, 3'd0, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cken         = tbl[i].cken;
      phi_man      = tbl[i].phi;
      bus.wr_valid = tbl[i].valid;
      bus.wr_data  = tbl[i].data;
      step();
      check($sformatf("vec%0d", i), tbl[i].e_pa_o, tbl[i].e_pa_wr, tbl[i].e_busy,
            tbl[i].e_level, tbl[i].e_ready);
    end
    bus.wr_valid = 1'b0;
    cken    = 1'b1;
    phi_man = 1'b0;

    // Asynchronous reset in the middle of a hold with two bytes queued.
    rst_n = 1'b0;
    #2;
    check("rst_async", 8'h00, 1'b0, 1'b0, 3'd0, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    check("rst_release", 8'h00, 1'b0, 1'b0, 3'd0, 1'b1);

    // Single byte with a pulse every 8 clocks.
    phi_mode = 1'b1;
    push(8'h09);
    wait_pop("single_pop", 8'h09, 3'd0, t);
    strobe_len(n);
    check_val("single_strobe", n, 8);
    for (int i = 0; i < 200 && busy; i++) step();
    check_val("single_busy_fall", edges - t, 80);
    check("single_after", 8'h09, 1'b0, 1'b0, 3'd0, 1'b1);

    // Three back-to-back bytes, queued before the pulses start.
    phi_mode = 1'b0;
    push(8'h09);
    push(8'h0A);
    push(8'h0B);
    check("b2b_queued", 8'h09, 1'b0, 1'b1, 3'd3, 1'b1);
    phi_mode = 1'b1;
    seq3[0] = 8'h09;
    seq3[1] = 8'h0A;
    seq3[2] = 8'h0B;
    t_prev  = 0;
    for (int i = 0; i < 3; i++) begin
      wait_pop($sformatf("b2b_pop%0d", i), seq3[i], 3'(2 - i), t);
      if (i > 0) check_val($sformatf("b2b_spacing%0d", i), t - t_prev, 88);
      t_prev = t;
      strobe_len(n);
      check_val($sformatf("b2b_strobe%0d", i), n, 8);
    end
    wait_idle("b2b_idle");

    // cken dropped for 10 clocks during the hold; push still accepted.
    push(8'h0C);
    wait_pop("freeze_pop", 8'h0C, 3'd0, t);
    n = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      if (pa_wr) n = n + 1;
    end
    cken = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.wr_valid = (i == 0);
      bus.wr_data  = 8'h0D;
      step();
      if (pa_wr) n = n + 1;
    end
    bus.wr_valid = 1'b0;
    check("freeze_mid", 8'h0C, 1'b1, 1'b1, 3'd1, 1'b1);
    cken = 1'b1;
    for (int i = 0; i < 50 && pa_wr; i++) begin
      step();
      if (pa_wr) n = n + 1;
    end
    check_val("freeze_strobe", n, 18);
    wait_pop("freeze_next", 8'h0D, 3'd0, t);
    wait_idle("freeze_idle");

    // Fill with pulses held low; fifth byte stalls until a pop frees a slot.
    phi_mode = 1'b0;
    phi_man  = 1'b0;
    push(8'h10);
    push(8'h11);
    push(8'h12);
    push(8'h13);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h14;
    step();
    check("full_stall0", 8'h0D, 1'b0, 1'b1, 3'd4, 1'b0);
    step();
    check("full_stall1", 8'h0D, 1'b0, 1'b1, 3'd4, 1'b0);
    phi_man = 1'b1;
    step();
    check("full_pop", 8'h10, 1'b1, 1'b1, 3'd3, 1'b1);
    phi_man = 1'b0;
    step();
    check("full_refill", 8'h10, 1'b1, 1'b1, 3'd4, 1'b0);
    bus.wr_valid = 1'b0;
    phi_mode = 1'b1;
    wait_pop("full_drain0", 8'h11, 3'd3, t);
    wait_pop("full_drain1", 8'h12, 3'd2, t);
    wait_pop("full_drain2", 8'h13, 3'd1, t);
    wait_pop("full_drain3", 8'h14, 3'd0, t);
    wait_idle("full_idle");

    // Push and pop on the same edge with two bytes queued.
    phi_mode = 1'b0;
    phi_man  = 1'b0;
    push(8'h21);
    push(8'h22);
    check("pp_queued", 8'h14, 1'b0, 1'b1, 3'd2, 1'b1);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h23;
    phi_man      = 1'b1;
    step();
    check("pp_same_edge", 8'h21, 1'b1, 1'b1, 3'd2, 1'b1);
    bus.wr_valid = 1'b0;
    phi_man      = 1'b0;
    phi_mode     = 1'b1;
    wait_pop("pp_pop1", 8'h22, 3'd1, t);
    wait_pop("pp_pop2", 8'h23, 3'd0, t);
    wait_idle("pp_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running at 500000, want finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
